fetch_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register of the pipelined RV32 core; sits directly upstream of instruction decode and the control unit.
- Holds the PC and drives the instruction-memory address.
- Selects the next PC from sequential, branch/jump redirect, stall, or halt.
- Presents the latched instruction, its PC and PC+4 to decode, with flush-to-NOP and sticky halt on ECALL/EBREAK-style halt requests.

---
 rtl/fetch_stage.sv | 101 ++++++++++
 tb/tb_fetch_stage.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// RV32 fetch stage and IF/ID register. Redirect-to-target latency is two edges (bubble then target).
// A stall holds the PC and IF/ID. A halt freezes the stage until reset.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        halt_req,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);

    typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_ipc;
    logic [31:0] r_pc4;
    logic        r_valid;
    logic [31:0] r_count;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_inst_nxt;
    logic [31:0] w_ipc_nxt;
    logic [31:0] w_pc4_nxt;
    logic        w_valid_nxt;
    logic [31:0] w_count_nxt;
    logic [31:0] w_pc_plus4;

    assign w_pc_plus4 = r_pc + 32'd4;

    // Priority: halted state, redirect, halt request, stall, sequential fetch.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_inst_nxt  = r_inst;
        w_ipc_nxt   = r_ipc;
        w_pc4_nxt   = r_pc4;
        w_valid_nxt = r_valid;
        w_count_nxt = r_count;
        if (r_state == S_RUN) begin
            if (branch_taken) begin
                w_pc_nxt    = {branch_target[31:2], 2'b00};
                w_inst_nxt  = NOP_INST;
                w_valid_nxt = 1'b0;
            end else if (halt_req) begin
                w_state_nxt = S_HALT;
                w_inst_nxt  = NOP_INST;
                w_valid_nxt = 1'b0;
            end else if (!stall) begin
                w_pc_nxt    = w_pc_plus4;
                w_inst_nxt  = imem_rdata;
                w_ipc_nxt   = r_pc;
                w_pc4_nxt   = w_pc_plus4;
                w_valid_nxt = 1'b1;
                w_count_nxt = r_count + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RUN;
            r_pc    <= RESET_PC;
            r_inst  <= NOP_INST;
            r_ipc   <= 32'd0;
            r_pc4   <= 32'd0;
            r_valid <= 1'b0;
            r_count <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_inst  <= w_inst_nxt;
            r_ipc   <= w_ipc_nxt;
            r_pc4   <= w_pc4_nxt;
            r_valid <= w_valid_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign imem_addr   = r_pc;
    assign if_id_inst  = r_inst;
    assign if_id_pc    = r_ipc;
    assign if_id_pc4   = r_pc4;
    assign if_id_valid = r_valid;
    assign halted      = (r_state == S_HALT);
    assign fetch_count = r_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic against a behavioural model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        halt_req;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        halted;
    logic [31:0] fetch_count;

    int n_tests = 0;
    int n_fail  = 0;

    // behavioural model state
    logic [31:0] m_pc, m_inst, m_ipc, m_pc4, m_count;
    logic        m_valid, m_halted;

    fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .halt_req(halt_req), .if_id_inst(if_id_inst), .if_id_pc(if_id_pc),
        .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid), .halted(halted),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_word = 32'h0050_0093;
            32'h0000_0004: mem_word = 32'h00A0_0113;
            default:       mem_word = ((a ^ 32'h5A5A_0000) * 32'h0001_0003) + 32'h0000_0013;
        endcase
    endfunction

    always_comb imem_rdata = mem_word(imem_addr);

    task automatic model_reset();
        m_pc = 32'h0; m_inst = NOP; m_ipc = 32'h0; m_pc4 = 32'h0;
        m_valid = 1'b0; m_halted = 1'b0; m_count = 32'h0;
    endtask

    // One clock edge of the architectural rules, applied to the sampled inputs.
    task automatic model_edge();
        if (m_halted) begin
        end else if (branch_taken) begin
            m_pc = branch_target & 32'hFFFF_FFFC;
            m_inst = NOP; m_valid = 1'b0;
        end else if (halt_req) begin
            m_halted = 1'b1; m_inst = NOP; m_valid = 1'b0;
        end else if (!stall) begin
            m_inst = mem_word(m_pc); m_ipc = m_pc; m_pc4 = m_pc + 32'd4;
            m_pc = m_pc + 32'd4; m_valid = 1'b1; m_count = m_count + 32'd1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clear_inputs();
        stall = 1'b0; branch_taken = 1'b0; halt_req = 1'b0; branch_target = 32'h0;
    endtask

    task automatic test_reset();
        n_tests++;
        if (imem_addr !== 32'h0 || if_id_inst !== NOP || if_id_pc !== 32'h0 || if_id_pc4 !== 32'h0 ||
            if_id_valid !== 1'b0 || halted !== 1'b0 || fetch_count !== 32'h0) begin
            n_fail++;
            $display("FAIL reset: addr=%h inst=%h pc=%h pc4=%h v=%b h=%b cnt=%0d, required 0/00000013/0/0/0/0/0",
                     imem_addr, if_id_inst, if_id_pc, if_id_pc4, if_id_valid, halted, fetch_count);
        end
    endtask

    task automatic test_sequential();
        step();
        n_tests++;
        if (if_id_inst !== 32'h0050_0093 || if_id_pc !== 32'h0 || if_id_pc4 !== 32'h4 ||
            if_id_valid !== 1'b1 || fetch_count !== 32'd1) begin
            n_fail++;
            $display("FAIL seq_edge1: inst=%h pc=%h pc4=%h v=%b cnt=%0d, required 00500093/0/4/1/1",
                     if_id_inst, if_id_pc, if_id_pc4, if_id_valid, fetch_count);
        end
        step();
        n_tests++;
        if (if_id_inst !== 32'h00A0_0113 || if_id_pc !== 32'h4 || if_id_pc4 !== 32'h8 ||
            fetch_count !== 32'd2 || imem_addr !== 32'h8) begin
            n_fail++;
            $display("FAIL seq_edge2: inst=%h pc=%h pc4=%h cnt=%0d addr=%h, required 00a00113/4/8/2/8",
                     if_id_inst, if_id_pc, if_id_pc4, fetch_count, imem_addr);
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_tests++;
            if (imem_addr !== 32'h8 || if_id_inst !== 32'h00A0_0113 || if_id_pc !== 32'h4 ||
                if_id_valid !== 1'b1 || fetch_count !== 32'd2) begin
                n_fail++;
                $display("FAIL stall_hold: addr=%h inst=%h pc=%h v=%b cnt=%0d, required 8/00a00113/4/1/2",
                         imem_addr, if_id_inst, if_id_pc, if_id_valid, fetch_count);
            end
        end
        stall = 1'b0;
        step();
        n_tests++;
        if (if_id_inst !== mem_word(32'h8) || if_id_pc !== 32'h8 || fetch_count !== 32'd3 || imem_addr !== 32'hC) begin
            n_fail++;
            $display("FAIL stall_release: inst=%h pc=%h cnt=%0d addr=%h, required %h/8/3/c",
                     if_id_inst, if_id_pc, fetch_count, imem_addr, mem_word(32'h8));
        end
    endtask

    task automatic test_redirect();
        branch_taken = 1'b1; branch_target = 32'h0000_0042; stall = 1'b1;
        step();
        clear_inputs();
        n_tests++;
        if (imem_addr !== 32'h40 || if_id_valid !== 1'b0 || if_id_inst !== NOP || if_id_pc !== 32'h8 || if_id_pc4 !== 32'hC) begin
            n_fail++;
            $display("FAIL redirect_bubble: addr=%h v=%b inst=%h pc=%h pc4=%h, required 40/0/00000013/8/c",
                     imem_addr, if_id_valid, if_id_inst, if_id_pc, if_id_pc4);
        end
        step();
        n_tests++;
        if (if_id_inst !== mem_word(32'h40) || if_id_pc !== 32'h40 || if_id_pc4 !== 32'h44 || if_id_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL redirect_target: inst=%h pc=%h pc4=%h v=%b, required %h/40/44/1",
                     if_id_inst, if_id_pc, if_id_pc4, if_id_valid, mem_word(32'h40));
        end
    endtask

    task automatic test_halt();
        logic [31:0] cnt_frozen;
        branch_taken = 1'b1; branch_target = 32'h10;
        step();
        clear_inputs();
        halt_req = 1'b1;
        step();
        clear_inputs();
        cnt_frozen = m_count;
        n_tests++;
        if (halted !== 1'b1 || if_id_valid !== 1'b0 || if_id_inst !== NOP || imem_addr !== 32'h10) begin
            n_fail++;
            $display("FAIL halt_enter: h=%b v=%b inst=%h addr=%h, required 1/0/00000013/10",
                     halted, if_id_valid, if_id_inst, imem_addr);
        end
        for (int i = 0; i < 5; i++) begin
            stall = 1'($urandom_range(0, 1)); branch_taken = 1'($urandom_range(0, 1));
            branch_target = $urandom;
            step();
            n_tests++;
            if (imem_addr !== 32'h10 || fetch_count !== cnt_frozen || halted !== 1'b1 || if_id_inst !== NOP) begin
                n_fail++;
                $display("FAIL halt_frozen: addr=%h cnt=%0d h=%b inst=%h, required 10/%0d/1/00000013",
                         imem_addr, fetch_count, halted, if_id_inst, cnt_frozen);
            end
        end
        clear_inputs();
        rst = 1'b1; model_reset(); #1;
        n_tests++;
        if (halted !== 1'b0 || imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL halt_reset: h=%b addr=%h, required 0/0", halted, imem_addr);
        end
        rst = 1'b0;
    endtask

    task automatic test_branch_beats_halt();
        branch_taken = 1'b1; halt_req = 1'b1; branch_target = 32'h80;
        step();
        clear_inputs();
        n_tests++;
        if (halted !== 1'b0 || imem_addr !== 32'h80) begin
            n_fail++;
            $display("FAIL branch_over_halt: h=%b addr=%h, required 0/80", halted, imem_addr);
        end
        step();
        n_tests++;
        if (if_id_inst !== mem_word(32'h80) || if_id_pc !== 32'h80 || if_id_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL branch_over_halt_fetch: inst=%h pc=%h v=%b, required %h/80/1",
                     if_id_inst, if_id_pc, if_id_valid, mem_word(32'h80));
        end
    endtask

    task automatic test_wrap_async_reset();
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
        step();
        clear_inputs();
        n_tests++;
        if (imem_addr !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL wrap_target: addr=%h, required fffffffc", imem_addr);
        end
        step();
        n_tests++;
        if (imem_addr !== 32'h0 || if_id_pc !== 32'hFFFF_FFFC || if_id_pc4 !== 32'h0 || if_id_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap: addr=%h pc=%h pc4=%h v=%b, required 0/fffffffc/0/1",
                     imem_addr, if_id_pc, if_id_pc4, if_id_valid);
        end
        #1 rst = 1'b1; model_reset();
        #1;
        n_tests++;
        if (imem_addr !== 32'h0 || if_id_inst !== NOP || if_id_pc !== 32'h0 || if_id_pc4 !== 32'h0 ||
            if_id_valid !== 1'b0 || halted !== 1'b0 || fetch_count !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: addr=%h inst=%h pc=%h pc4=%h v=%b h=%b cnt=%0d, required reset values",
                     imem_addr, if_id_inst, if_id_pc, if_id_pc4, if_id_valid, halted, fetch_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            stall         = ($urandom_range(0, 3) == 0);
            branch_taken  = ($urandom_range(0, 7) == 0);
            halt_req      = ($urandom_range(0, 31) == 0);
            branch_target = $urandom;
            step();
            n_tests++;
            if (imem_addr !== m_pc || if_id_inst !== m_inst || if_id_pc !== m_ipc || if_id_pc4 !== m_pc4 ||
                if_id_valid !== m_valid || halted !== m_halted || fetch_count !== m_count) begin
                n_fail++;
                $display("FAIL random[%0d]: addr=%h inst=%h pc=%h pc4=%h v=%b h=%b cnt=%0d, required %h/%h/%h/%h/%b/%b/%0d",
                         i, imem_addr, if_id_inst, if_id_pc, if_id_pc4, if_id_valid, halted, fetch_count,
                         m_pc, m_inst, m_ipc, m_pc4, m_valid, m_halted, m_count);
            end
            if (m_halted && $urandom_range(0, 2) == 0) begin
                clear_inputs();
                rst = 1'b1; model_reset(); #1;
                rst = 1'b0;
            end
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        test_sequential();
        test_stall();
        test_redirect();
        test_halt();
        test_branch_beats_halt();
        test_wrap_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
